half_adder: RTL and testbench
=============================

# half_adder

Registered, parameterisable half adder: adds two unsigned WIDTH-bit operands with no carry-in and returns a WIDTH-bit sum plus a carry-out. At WIDTH=1 it is the classic single-bit half adder (s = a XOR b, c = a AND b). It is a leaf arithmetic primitive for datapaths that need a qualified, registered sum. A saturating carry-event counter is provided for debug.

## Interface
Parameters:
- WIDTH, default 1: operand and sum width in bits, at least 1.
- CNT_W, default 8: carry-event counter width in bits, at least 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a and b on the current clock edge.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  qualifies s and c.
- s  output  WIDTH  sum, (a + b) mod 2^WIDTH.
- c  output  1  carry-out, bit WIDTH of a + b.
- carry_cnt  output  CNT_W  saturating count of accepted operations with c = 1.

## Operation
- Arithmetic: compute {c, s} = a + b at WIDTH+1 bits, zero-extended. No carry-in and no overflow flag.
  - At WIDTH=1: s = a ^ b and c = a & b.
- Accept: a rising clk edge with in_valid=1 captures the result into the output registers and sets out_valid=1.
- Idle: an edge with in_valid=0 clears out_valid to 0.
  - s and c hold their last captured values.
  - Consumers ignore s and c while out_valid=0.
- Operand changes while in_valid=0 have no effect on any output.
- There is no backpressure; a new operation is accepted on every cycle that in_valid=1.
- carry_cnt:
  - Increments by 1 on each accepted operation whose c is 1.
  - Saturates at 2^CNT_W − 1 and never wraps.
  - Cleared only by rst.
- Reset: rst=1 forces out_valid=0, s=0, c=0 and carry_cnt=0 immediately, independent of clk.
  - Any operation captured in the same cycle as reset is lost.
  - The first edge after rst deasserts operates normally.
- Undriven (X) inputs with in_valid=0 must not propagate X into registered state.

## Timing
- Latency: 1 cycle without the configuration macro, 2 cycles with it. Latency is measured from the sampling edge of in_valid to out_valid=1.
- Throughput: one operation per cycle; back-to-back operations emerge in order, one per cycle.
- Outputs are driven only from registers; there is no combinational input-to-output path.
- All outputs change only on a rising clk edge or an rst assertion.
- carry_cnt updates in the same cycle that the corresponding c appears with out_valid=1.

## Configuration
- HALF_ADDER_PIPE_EN undefined: single register stage, latency 1.
- HALF_ADDER_PIPE_EN defined:
  - Adds a second register stage carrying the valid flag, sum and carry, for timing closure at large WIDTH.
  - Latency becomes 2; throughput stays one operation per cycle.
  - rst clears both stages.
  - carry_cnt counts at the output stage.
- The port list and parameters are identical in both builds.

## Test plan
- WIDTH=1 truth table, one operation per cycle with in_valid=1: (a,b) = (0,0)→(c,s)=(0,0); (0,1)→(0,1); (1,0)→(0,1); (1,1)→(1,0). After the sequence, carry_cnt=1.
- WIDTH=8 boundary operations:
  - 0xFF+0x01 → s=0x00, c=1.
  - 0x7F+0x80 → s=0xFF, c=0.
  - 0xFF+0xFF → s=0xFE, c=1.
  - 0x00+0x00 → s=0x00, c=0.
- Valid gating: an operation, then in_valid=0 for 3 cycles with a and b toggling.
  - out_valid must fall after the latency and stay 0.
  - s, c and carry_cnt must hold their values.
- Saturation: with CNT_W=2, send 5 operations of 1+1 at WIDTH=1. carry_cnt must read 1, 2, 3, 3, 3.
- Asynchronous reset mid-stream: assert rst between clock edges while out_valid=1 and carry_cnt=2.
  - All outputs must read 0 before the next edge.
  - After release, the first operation 1+0 must give s=1, c=0.
- Both builds: with HALF_ADDER_PIPE_EN defined, repeat the truth-table test and check that out_valid arrives exactly 2 cycles after each in_valid.

Source files
------------

// File: rtl/half_adder.sv
// rtl/half_adder.sv - registered WIDTH-bit half adder with saturating carry counter (optional second stage under HALF_ADDER_PIPE_EN)
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic [CNT_W-1:0] carry_cnt
);

    // Zero-extended add: the top bit is the carry-out, there is no carry-in.
    logic [WIDTH:0] sum_full;
    assign sum_full = {1'b0, a} + {1'b0, b};

    logic             st1_valid;
    logic [WIDTH-1:0] st1_sum;
    logic             st1_carry;

    // Result register; data only loads when qualified so idle X operands never reach state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st1_valid <= 1'b0;
            st1_sum   <= '0;
            st1_carry <= 1'b0;
        end else begin
            st1_valid <= in_valid;
            if (in_valid) begin
                st1_sum   <= sum_full[WIDTH-1:0];
                st1_carry <= sum_full[WIDTH];
            end
        end
    end

    // Strobe and carry of the operation entering the output stage on this edge.
    logic out_load;
    logic out_load_carry;

`ifdef HALF_ADDER_PIPE_EN
    logic             st2_valid;
    logic [WIDTH-1:0] st2_sum;
    logic             st2_carry;

    // Retiming stage: copies stage one forward, holding data while stage one is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st2_valid <= 1'b0;
            st2_sum   <= '0;
            st2_carry <= 1'b0;
        end else begin
            st2_valid <= st1_valid;
            if (st1_valid) begin
                st2_sum   <= st1_sum;
                st2_carry <= st1_carry;
            end
        end
    end

    assign out_load       = st1_valid;
    assign out_load_carry = st1_carry;
    assign out_valid      = st2_valid;
    assign s              = st2_sum;
    assign c              = st2_carry;
`else
    assign out_load       = in_valid;
    assign out_load_carry = sum_full[WIDTH];
    assign out_valid      = st1_valid;
    assign s              = st1_sum;
    assign c              = st1_carry;
`endif

    // Carry-event counter tracks the output stage so it moves with the visible c; it sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if (out_load && out_load_carry && (carry_cnt != '1)) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - scoreboard bench for half_adder (WIDTH=1/CNT_W=2 and WIDTH=8/CNT_W=8 instances)
module tb_half_adder;

`ifdef HALF_ADDER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        int         due;
        logic [7:0] s;
        logic       c;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       iv1, a1, b1;
    logic       ov1, s1, c1;
    logic [1:0] cnt1;

    logic       iv8;
    logic [7:0] a8, b8;
    logic       ov8;
    logic [7:0] s8;
    logic       c8;
    logic [7:0] cnt8;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q1[$];
    exp_t q8[$];
    logic [7:0] l1s, l1cnt, l8s, l8cnt;
    logic       l1c, l8c;

    always #5 clk = ~clk;

    half_adder #(.WIDTH(1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1),
        .out_valid(ov1), .s(s1), .c(c1), .carry_cnt(cnt1)
    );

    half_adder #(.WIDTH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8),
        .out_valid(ov8), .s(s8), .c(c8), .carry_cnt(cnt8)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_model();
        q1.delete();
        q8.delete();
        l1s = '0; l1c = 1'b0; l1cnt = '0;
        l8s = '0; l8c = 1'b0; l8cnt = '0;
    endtask

    task automatic op1(input logic a, input logic b, input logic s, input logic c, input logic [7:0] cnt);
        exp_t e;
        iv1 = 1'b1; a1 = a; b1 = b;
        e.due = cyc + LAT; e.s = {7'b0, s}; e.c = c; e.cnt = cnt;
        q1.push_back(e);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s, input logic c, input logic [7:0] cnt);
        exp_t e;
        iv8 = 1'b1; a8 = a; b8 = b;
        e.due = cyc + LAT; e.s = s; e.c = c; e.cnt = cnt;
        q8.push_back(e);
    endtask

    task automatic check1();
        exp_t e;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            cmp("u1_out_valid", ov1, 1);
            cmp("u1_s", s1, e.s);
            cmp("u1_c", c1, e.c);
            cmp("u1_carry_cnt", cnt1, e.cnt);
            l1s = e.s; l1c = e.c; l1cnt = e.cnt;
        end else begin
            cmp("u1_idle_out_valid", ov1, 0);
            cmp("u1_hold_s", s1, l1s);
            cmp("u1_hold_c", c1, l1c);
            cmp("u1_hold_cnt", cnt1, l1cnt);
        end
    endtask

    task automatic check8();
        exp_t e;
        if (q8.size() > 0 && q8[0].due == cyc) begin
            e = q8.pop_front();
            cmp("u8_out_valid", ov8, 1);
            cmp("u8_s", s8, e.s);
            cmp("u8_c", c8, e.c);
            cmp("u8_carry_cnt", cnt8, e.cnt);
            l8s = e.s; l8c = e.c; l8cnt = e.cnt;
        end else begin
            cmp("u8_idle_out_valid", ov8, 0);
            cmp("u8_hold_s", s8, l8s);
            cmp("u8_hold_c", c8, l8c);
            cmp("u8_hold_cnt", cnt8, l8cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check1();
        check8();
        iv1 = 1'b0;
        iv8 = 1'b0;
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        clear_model();
    endtask

    initial begin
        rst = 1'b1;
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        iv8 = 1'b0; a8 = '0;   b8 = '0;
        clear_model();

        tick();
        tick();
        rst = 1'b0;

        op1(0, 0, 0, 0, 0); op8(8'hFF, 8'h01, 8'h00, 1, 1); tick();
        op1(0, 1, 1, 0, 0); op8(8'h7F, 8'h80, 8'hFF, 0, 1); tick();
        op1(1, 0, 1, 0, 0); op8(8'hFF, 8'hFF, 8'hFE, 1, 2); tick();
        op1(1, 1, 0, 1, 1); op8(8'h00, 8'h00, 8'h00, 0, 2); tick();
        repeat (LAT + 1) tick();
        cmp("truth_table_carry_cnt", cnt1, 1);
        cmp("boundary_carry_cnt", cnt8, 2);

        op8(8'h01, 8'hFF, 8'h00, 1, 3); tick();
        for (int i = 0; i < 3; i++) begin
            a1 = ~a1; b1 = ~b1;
            a8 = (i == 1) ? 'x : 8'($urandom);
            b8 = (i == 1) ? 'x : ~a8;
            tick();
        end
        repeat (LAT) tick();
        cmp("gating_hold_cnt", cnt8, 3);

        reset_pulse();
        for (int i = 0; i < 5; i++) begin
            op1(1, 1, 0, 1, (i < 3) ? 8'(i + 1) : 8'd3);
            tick();
        end
        repeat (LAT + 1) tick();
        cmp("saturated_carry_cnt", cnt1, 3);

        reset_pulse();
        op1(1, 1, 0, 1, 1); tick();
        op1(1, 1, 0, 1, 2); tick();
        repeat (LAT - 1) tick();
        cmp("pre_reset_out_valid", ov1, 1);
        cmp("pre_reset_carry_cnt", cnt1, 2);
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_u1_out_valid", ov1, 0);
        cmp("async_rst_u1_s", s1, 0);
        cmp("async_rst_u1_c", c1, 0);
        cmp("async_rst_u1_carry_cnt", cnt1, 0);
        cmp("async_rst_u8_out_valid", ov8, 0);
        cmp("async_rst_u8_s", s8, 0);
        cmp("async_rst_u8_carry_cnt", cnt8, 0);
        #1 rst = 1'b0;
        clear_model();
        op1(1, 0, 1, 0, 0); tick();
        repeat (LAT) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
